// File: rtl/composite_ecc_block.sv
// composite_ecc_block: odd-parity check plus Hamming(12,8) SEC over one data word,
// with single-bit fault injection ahead of the decoder and registered outputs.
module composite_ecc_block #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  inject_en,
    input  logic [3:0]            inject_pos,
    input  logic                  inject_parity,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error_detected,
    output logic                  error_corrected
);

    // The codeword layout below is hard-wired for an 8-bit word.
    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("composite_ecc_block: DATA_WIDTH must be 8, got %0d", DATA_WIDTH);
    end

    logic [7:0]            d;
    logic                  pbit;
    logic                  pbit_rx;
    logic [3:0]            hp;          // Hamming check bits {p3,p2,p1,p0}
    logic [11:0]           cw;          // encoded codeword, bit i = position i+1
    logic [11:0]           flip_mask;
    logic [11:0]           cw_rx;       // codeword after fault injection
    logic [11:0]           cw_fix;      // codeword after single-bit correction
    logic [3:0]            syndrome;
    logic                  parity_err;

    logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
    logic                  error_detected_d, error_detected_q;
    logic                  error_corrected_d, error_corrected_q;

    // Encode, inject, decode and correct: the whole datapath is combinational.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can
        // leave one unassigned, which would infer a latch.
        d                 = data_in[7:0];
        flip_mask         = '0;
        data_out_d        = '0;
        error_detected_d  = 1'b0;
        error_corrected_d = 1'b0;

        // Odd parity over {pbit, data}.
        pbit = ~^d;

        hp[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        hp[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        hp[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        hp[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        cw    = {d[7], d[6], d[5], d[4], hp[3], d[3], d[2], d[1], hp[2], d[0], hp[1], hp[0]};

        // Positions 12..15 do not exist in the codeword, so they inject nothing.
        if (inject_en && (inject_pos <= 4'd11)) begin
            flip_mask[inject_pos] = 1'b1;
        end
        cw_rx   = cw ^ flip_mask;
        pbit_rx = pbit ^ inject_parity;

        syndrome[0] = cw_rx[0] ^ cw_rx[2] ^ cw_rx[4] ^ cw_rx[6] ^ cw_rx[8] ^ cw_rx[10];
        syndrome[1] = cw_rx[1] ^ cw_rx[2] ^ cw_rx[5] ^ cw_rx[6] ^ cw_rx[9] ^ cw_rx[10];
        syndrome[2] = cw_rx[3] ^ cw_rx[4] ^ cw_rx[5] ^ cw_rx[6] ^ cw_rx[11];
        syndrome[3] = cw_rx[7] ^ cw_rx[8] ^ cw_rx[9] ^ cw_rx[10] ^ cw_rx[11];

        // Parity is checked on the received data bits, before any correction.
        parity_err = ~^{pbit_rx, cw_rx[11], cw_rx[10], cw_rx[9], cw_rx[8],
                        cw_rx[6], cw_rx[5], cw_rx[4], cw_rx[2]};

        // Syndromes 13..15 point outside the codeword: flag but pass through.
        cw_fix = cw_rx;
        if ((syndrome != 4'd0) && (syndrome <= 4'd12)) begin
            cw_fix[syndrome - 4'd1] = ~cw_rx[syndrome - 4'd1];
            error_corrected_d       = 1'b1;
        end

        data_out_d       = {cw_fix[11], cw_fix[10], cw_fix[9], cw_fix[8],
                            cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
        error_detected_d = parity_err | (syndrome != 4'd0);
    end

    // Output registers; asynchronous clear discards any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its pre-edge input regardless of statement order.
        if (!rst_n) begin
            data_out_q        <= '0;
            error_detected_q  <= 1'b0;
            error_corrected_q <= 1'b0;
        end else begin
            data_out_q        <= data_out_d;
            error_detected_q  <= error_detected_d;
            error_corrected_q <= error_corrected_d;
        end
    end

    assign data_out        = data_out_q;
    assign error_detected  = error_detected_q;
    assign error_corrected = error_corrected_q;

endmodule

// File: tb/tb_composite_ecc_block.sv
// tb_composite_ecc_block: directed and randomized checks of composite_ecc_block
// against a position-based Hamming/parity reference model.
module tb_composite_ecc_block;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       inject_en;
    logic [3:0] inject_pos;
    logic       inject_parity;
    logic [7:0] data_out;
    logic       error_detected;
    logic       error_corrected;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected registered outputs for the word most recently clocked in.
    logic [7:0] exp_data;
    logic       exp_det;
    logic       exp_cor;

    composite_ecc_block #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .inject_en      (inject_en),
        .inject_pos     (inject_pos),
        .inject_parity  (inject_parity),
        .data_out       (data_out),
        .error_detected (error_detected),
        .error_corrected(error_corrected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: classic Hamming with 1-based positions; parity bits sit
    // at powers of two and the syndrome is the XOR of the positions of set bits.
    // Returns {detected, corrected, data}.
    function automatic logic [9:0] model(input logic [7:0] d, input logic ie,
                                         input logic [3:0] ipos, input logic ip);
        int         dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [12:0] c = '0;
        int         syn = 0;
        int         ones = 0;
        logic       pbit;
        logic [7:0] dout;
        logic       perr;
        for (int k = 0; k < 8; k++) c[dpos[k]] = d[k];
        for (int p = 1; p <= 12; p++) if (c[p]) syn = syn ^ p;
        for (int b = 1; b <= 8; b = b * 2) c[b] = ((syn & b) != 0);
        pbit = ($countones(d) % 2) == 0;
        if (ie && ipos <= 11) c[ipos + 1] = ~c[ipos + 1];
        for (int k = 0; k < 8; k++) ones += c[dpos[k]];
        ones += (pbit ^ ip);
        perr = (ones % 2) == 0;
        syn = 0;
        for (int p = 1; p <= 12; p++) if (c[p]) syn = syn ^ p;
        if (syn >= 1 && syn <= 12) c[syn] = ~c[syn];
        for (int k = 0; k < 8; k++) dout[k] = c[dpos[k]];
        return {perr || (syn != 0), (syn >= 1 && syn <= 12), dout};
    endfunction

    // Apply one word just after a rising edge, confirm the outputs still hold
    // the previous word (one-cycle latency), then check the new result.
    task automatic drive(input string tag, input logic [7:0] d, input logic ie,
                         input logic [3:0] ipos, input logic ip);
        logic [9:0] r;
        data_in       = d;
        inject_en     = ie;
        inject_pos    = ipos;
        inject_parity = ip;
        #2;
        check({tag, "_hold"}, {data_out, error_detected, error_corrected},
              {exp_data, exp_det, exp_cor});
        r = model(d, ie, ipos, ip);
        exp_det  = r[9];
        exp_cor  = r[8];
        exp_data = r[7:0];
        @(posedge clk);
        #1;
        check({tag, "_data"}, data_out, exp_data);
        check({tag, "_det"}, error_detected, exp_det);
        check({tag, "_cor"}, error_corrected, exp_cor);
    endtask

    initial begin
        rst_n         = 1'b0;
        data_in       = 8'hFF;
        inject_en     = 1'b0;
        inject_pos    = 4'd0;
        inject_parity = 1'b0;
        exp_data      = 8'h00;
        exp_det       = 1'b0;
        exp_cor       = 1'b0;

        // Reset held across edges with data_in = FF.
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_flags", {error_detected, error_corrected}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_data", data_out, 8'hFF);
        check("rel_flags", {error_detected, error_corrected}, 2'b00);
        exp_data = 8'hFF;

        // Directed cases with known answers, also compared against constants.
        drive("a5_clean", 8'hA5, 1'b0, 4'd0, 1'b0);
        check("a5_clean_k", {data_out, error_detected, error_corrected}, {8'hA5, 2'b00});
        drive("3c_clean", 8'h3C, 1'b0, 4'd0, 1'b0);
        check("3c_clean_k", {data_out, error_detected, error_corrected}, {8'h3C, 2'b00});
        drive("a5_d0", 8'hA5, 1'b1, 4'd2, 1'b0);
        check("a5_d0_k", {data_out, error_detected, error_corrected}, {8'hA5, 2'b11});
        drive("a5_p0", 8'hA5, 1'b1, 4'd0, 1'b0);
        check("a5_p0_k", {data_out, error_detected, error_corrected}, {8'hA5, 2'b11});
        drive("a5_par", 8'hA5, 1'b0, 4'd0, 1'b1);
        check("a5_par_k", {data_out, error_detected, error_corrected}, {8'hA5, 2'b10});
        drive("a5_pos13", 8'hA5, 1'b1, 4'd13, 1'b0);
        check("a5_pos13_k", {data_out, error_detected, error_corrected}, {8'hA5, 2'b00});
        drive("a5_dbl", 8'hA5, 1'b1, 4'd6, 1'b1);
        check("a5_dbl_k", {data_out, error_detected, error_corrected}, {8'hA5, 2'b11});

        // Sweep every codeword position for 3C.
        for (int p = 0; p < 12; p++) begin
            drive($sformatf("3c_pos%0d", p), 8'h3C, 1'b1, 4'(p), 1'b0);
            check($sformatf("3c_pos%0d_k", p), {data_out, error_detected, error_corrected},
                  {8'h3C, 2'b11});
        end

        // Randomized back-to-back words.
        for (int i = 0; i < 300; i++) begin
            drive($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom),
                  4'($urandom), 1'(($urandom % 4) == 0));
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        drive("pre_rst", 8'h5A, 1'b1, 4'd9, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", {data_out, error_detected, error_corrected}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_data = 8'h00;
        exp_det  = 1'b0;
        exp_cor  = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_data", data_out, 8'h5A);
        check("post_rst_flags", {error_detected, error_corrected}, 2'b11);
        exp_data = 8'h5A;
        exp_det  = 1'b1;
        exp_cor  = 1'b1;
        drive("post_rst_next", 8'hC3, 1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
